// File: rtl/uart_pkg.sv
// Shared constants and state type for the UART memory-mapped bridge.
package uart_pkg;

    localparam logic [7:0] UART_TXDATA_OFS = 8'h00;
    localparam logic [7:0] UART_RXDATA_OFS = 8'h04;
    localparam logic [7:0] UART_STATUS_OFS = 8'h08;
    localparam logic [7:0] UART_BAUD_OFS   = 8'h0C;
    localparam logic [7:0] UART_IRQEN_OFS  = 8'h10;

    localparam int UART_ST_TXFULL  = 0;
    localparam int UART_ST_RXEMPTY = 1;
    localparam int UART_ST_UPGRADE = 2;
    localparam int UART_ST_IRQ     = 3;

    typedef enum logic [2:0] {
        IDLE,
        TX_PUSH,
        RX_POP,
        RX_CAP,
        RESP
    } uart_br_state_t;

endpackage

// File: rtl/uart_mmio_bridge.sv
// Load/store register window in front of the UART manager byte interface.
// Optional interrupt source and IRQ_EN register enabled by UART_IRQ_EN.
module uart_mmio_bridge
    import uart_pkg::*;
#(
    parameter int unsigned ADDR_LEN = 5,
    parameter int unsigned XLEN     = 32,
    parameter logic [7:0]  BAUD_RST = 8'd18
) (
    input  logic                clk,
    input  logic                rstb,
    input  logic                mmio_req,
    input  logic                mmio_we,
    input  logic [ADDR_LEN-1:0] mmio_addr,
    input  logic [XLEN-1:0]     mmio_wdata,
    input  logic [XLEN/8-1:0]   mmio_be,
    output logic                mmio_ready,
    output logic                mmio_rvalid,
    output logic [XLEN-1:0]     mmio_rdata,
    output logic                uart_wr_req,
    output logic [7:0]          uart_wr_data,
    input  logic                uart_wr_ready,
    output logic                uart_rd_req,
    input  logic [7:0]          uart_rd_data,
    input  logic                uart_rd_ready,
    input  logic                uart_txfifo_full,
    input  logic                uart_rxfifo_empty,
    input  logic                during_sw_upgrade,
    output logic [7:0]          baudrate_cfg,
    output logic                irq
);

    uart_br_state_t    state_q, state_d;
    logic [7:0]        wr_data_q, wr_data_d;
    logic              pending_q, pending_d;
    logic [XLEN-1:0]   rdata_q, rdata_d;
    logic [7:0]        baud_q, baud_d;
    logic [ADDR_LEN-1:0] ofs;
    logic              is_tx, is_rx, is_status, is_baud, is_irqen;
    logic              pop;
    logic [XLEN-1:0]   rd_mux;

    assign ofs       = {mmio_addr[ADDR_LEN-1:2], 2'b00};
    assign is_tx     = (ofs == ADDR_LEN'(UART_TXDATA_OFS));
    assign is_rx     = (ofs == ADDR_LEN'(UART_RXDATA_OFS));
    assign is_status = (ofs == ADDR_LEN'(UART_STATUS_OFS));
    assign is_baud   = (ofs == ADDR_LEN'(UART_BAUD_OFS));
    assign is_irqen  = (ofs == ADDR_LEN'(UART_IRQEN_OFS));

`ifdef UART_IRQ_EN
    logic [1:0] irqen_q, irqen_d;
    logic       irq_q;

    always_ff @(posedge clk) begin
        if (!rstb) begin
            irqen_q <= 2'b00;
            irq_q   <= 1'b0;
        end else begin
            irqen_q <= irqen_d;
            irq_q   <= (irqen_q[0] & ~uart_rxfifo_empty)
                     | (irqen_q[1] & ~uart_txfifo_full);
        end
    end

    assign irq = irq_q;
`else
    assign irq = 1'b0;
`endif

    always_comb begin
        rd_mux = '0;
        if (is_status) begin
            rd_mux[UART_ST_TXFULL]  = uart_txfifo_full;
            rd_mux[UART_ST_RXEMPTY] = uart_rxfifo_empty;
            rd_mux[UART_ST_UPGRADE] = during_sw_upgrade;
            rd_mux[UART_ST_IRQ]     = irq;
        end
        if (is_baud) rd_mux[7:0] = baud_q;
`ifdef UART_IRQ_EN
        if (is_irqen) rd_mux[1:0] = irqen_q;
`endif
    end

    assign pop = ~uart_rxfifo_empty & ~during_sw_upgrade & uart_rd_ready;

    always_comb begin
        state_d   = state_q;
        wr_data_d = wr_data_q;
        pending_d = pending_q;
        rdata_d   = rdata_q;
        baud_d    = baud_q;
`ifdef UART_IRQ_EN
        irqen_d   = irqen_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (mmio_req) begin
                    rdata_d   = '0;
                    pending_d = 1'b0;
                    if (mmio_we && is_tx && mmio_be[0] && !during_sw_upgrade) begin
                        wr_data_d = mmio_wdata[7:0];
                        state_d   = TX_PUSH;
                    end else if (!mmio_we && is_rx) begin
                        state_d = RX_POP;
                    end else begin
                        if (!mmio_we) rdata_d = rd_mux;
                        if (mmio_we && is_baud && mmio_be[0]) baud_d = mmio_wdata[7:0];
`ifdef UART_IRQ_EN
                        if (mmio_we && is_irqen && mmio_be[0]) irqen_d = mmio_wdata[1:0];
`endif
                        // RX_CAP holds rdata, so plain register accesses answer at T+2
                        state_d = RX_CAP;
                    end
                end
            end
            TX_PUSH: if (uart_wr_ready) state_d = RESP;
            RX_POP: begin
                pending_d = pop;
                state_d   = RX_CAP;
            end
            RX_CAP: begin
                if (pending_q) rdata_d = XLEN'({1'b1, uart_rd_data});
                state_d = RESP;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstb) begin
            state_q   <= IDLE;
            wr_data_q <= 8'h00;
            pending_q <= 1'b0;
            rdata_q   <= '0;
            baud_q    <= BAUD_RST;
        end else begin
            state_q   <= state_d;
            wr_data_q <= wr_data_d;
            pending_q <= pending_d;
            rdata_q   <= rdata_d;
            baud_q    <= baud_d;
        end
    end

    assign mmio_ready   = rstb && (state_q == IDLE);
    assign mmio_rvalid  = rstb && (state_q == RESP);
    assign mmio_rdata   = mmio_rvalid ? rdata_q : '0;
    assign uart_wr_req  = rstb && (state_q == TX_PUSH);
    assign uart_wr_data = wr_data_q;
    assign uart_rd_req  = rstb && (state_q == RX_POP) && pop;
    assign baudrate_cfg = baud_q;

endmodule

// File: tb/tb_uart_mmio_bridge.sv
// Directed bench for uart_mmio_bridge: register map, handshakes, timing.
// The IRQ section follows whether UART_IRQ_EN is defined for the build.
module tb_uart_mmio_bridge;

    logic        clk = 1'b0;
    logic        rstb;
    logic        mmio_req;
    logic        mmio_we;
    logic [4:0]  mmio_addr;
    logic [31:0] mmio_wdata;
    logic [3:0]  mmio_be;
    logic        mmio_ready;
    logic        mmio_rvalid;
    logic [31:0] mmio_rdata;
    logic        uart_wr_req;
    logic [7:0]  uart_wr_data;
    logic        uart_wr_ready;
    logic        uart_rd_req;
    logic [7:0]  uart_rd_data;
    logic        uart_rd_ready;
    logic        uart_txfifo_full;
    logic        uart_rxfifo_empty;
    logic        during_sw_upgrade;
    logic [7:0]  baudrate_cfg;
    logic        irq;

    int n_assert = 0;
    int n_fail   = 0;
    int rx_loaded = 0;
    int pops_total = 0;

    always #5 clk = ~clk;

    // RX FIFO model: occupancy is bytes loaded minus bytes popped
    always @(posedge clk) if (uart_rd_req) pops_total <= pops_total + 1;
    assign uart_rxfifo_empty = (rx_loaded <= pops_total);

    uart_mmio_bridge dut (
        .clk               (clk),
        .rstb              (rstb),
        .mmio_req          (mmio_req),
        .mmio_we           (mmio_we),
        .mmio_addr         (mmio_addr),
        .mmio_wdata        (mmio_wdata),
        .mmio_be           (mmio_be),
        .mmio_ready        (mmio_ready),
        .mmio_rvalid       (mmio_rvalid),
        .mmio_rdata        (mmio_rdata),
        .uart_wr_req       (uart_wr_req),
        .uart_wr_data      (uart_wr_data),
        .uart_wr_ready     (uart_wr_ready),
        .uart_rd_req       (uart_rd_req),
        .uart_rd_data      (uart_rd_data),
        .uart_rd_ready     (uart_rd_ready),
        .uart_txfifo_full  (uart_txfifo_full),
        .uart_rxfifo_empty (uart_rxfifo_empty),
        .during_sw_upgrade (during_sw_upgrade),
        .baudrate_cfg      (baudrate_cfg),
        .irq               (irq)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_idle;
        for (int n = 0; n < 20 && !mmio_ready; n++) tick();
    endtask

    // One request; lat counts cycles from accept to the rvalid cycle
    task automatic access(input logic we, input logic [4:0] addr,
                          input logic [31:0] wd, input logic [3:0] be,
                          output int lat, output logic [31:0] data,
                          output int n_push, output int n_pop, output int pop_at);
        mmio_req   = 1'b1;
        mmio_we    = we;
        mmio_addr  = addr;
        mmio_wdata = wd;
        mmio_be    = be;
        wait_idle();
        tick();
        mmio_req = 1'b0;
        mmio_we  = 1'b0;
        lat = 1;
        data = 32'h0;
        n_push = 0;
        n_pop = 0;
        pop_at = 0;
        forever begin
            if (uart_wr_req && uart_wr_ready) n_push++;
            if (uart_rd_req) begin
                n_pop++;
                if (pop_at == 0) pop_at = lat;
            end
            if (mmio_rvalid) begin
                data = mmio_rdata;
                break;
            end
            if (lat >= 20) break;
            tick();
            lat++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, np, nr, pat, bad, cnt;
        logic [31:0] d;

        rstb = 1'b0;
        mmio_req = 1'b0;
        mmio_we = 1'b0;
        mmio_addr = 5'h0;
        mmio_wdata = 32'h0;
        mmio_be = 4'h0;
        uart_wr_ready = 1'b1;
        uart_rd_ready = 1'b1;
        uart_rd_data = 8'h5A;
        uart_txfifo_full = 1'b0;
        during_sw_upgrade = 1'b0;

        repeat (3) tick();
        chk("rst_ready", {31'h0, mmio_ready}, 32'h0);
        chk("rst_rvalid", {31'h0, mmio_rvalid}, 32'h0);
        chk("rst_rdata", mmio_rdata, 32'h0);
        chk("rst_wr_req", {31'h0, uart_wr_req}, 32'h0);
        chk("rst_wr_data", {24'h0, uart_wr_data}, 32'h0);
        chk("rst_rd_req", {31'h0, uart_rd_req}, 32'h0);
        chk("rst_baud", {24'h0, baudrate_cfg}, 32'h12);
        chk("rst_irq", {31'h0, irq}, 32'h0);
        rstb = 1'b1;
        tick();
        chk("post_rst_ready", {31'h0, mmio_ready}, 32'h1);

        access(1'b0, 5'h0C, 32'h0, 4'hF, lat, d, np, nr, pat);
        chk("baud_rd_lat", lat, 2);
        chk("baud_rd_data", d, 32'h12);

        wait_idle();
        mmio_req = 1'b1;
        mmio_we = 1'b1;
        mmio_addr = 5'h0C;
        mmio_wdata = 32'hFFFF_FF09;
        mmio_be = 4'hF;
        tick();
        mmio_req = 1'b0;
        mmio_we = 1'b0;
        chk("baud_wr_t1", {24'h0, baudrate_cfg}, 32'h09);
        chk("baud_wr_t1_rvalid", {31'h0, mmio_rvalid}, 32'h0);
        tick();
        chk("baud_wr_t2_rvalid", {31'h0, mmio_rvalid}, 32'h1);
        chk("baud_wr_t2_rdata", mmio_rdata, 32'h0);

        access(1'b1, 5'h0C, 32'h55, 4'hE, lat, d, np, nr, pat);
        access(1'b0, 5'h0C, 32'h0, 4'hF, lat, d, np, nr, pat);
        chk("baud_be0_guard", d, 32'h09);

        uart_txfifo_full = 1'b1;
        access(1'b0, 5'h08, 32'h0, 4'hF, lat, d, np, nr, pat);
        chk("status_full_empty", d, 32'h3);
        chk("status_lat", lat, 2);
        uart_txfifo_full = 1'b0;

        access(1'b0, 5'h14, 32'h0, 4'hF, lat, d, np, nr, pat);
        chk("unmapped_rd", d, 32'h0);
        chk("unmapped_rd_lat", lat, 2);
        access(1'b1, 5'h18, 32'hABCD, 4'hF, lat, d, np, nr, pat);
        chk("unmapped_wr_lat", lat, 2);

        access(1'b0, 5'h00, 32'h0, 4'hF, lat, d, np, nr, pat);
        chk("txdata_rd", d, 32'h0);
        chk("txdata_rd_push", np, 0);

        access(1'b1, 5'h00, 32'h41, 4'hE, lat, d, np, nr, pat);
        chk("tx_be0_lat", lat, 2);
        chk("tx_be0_push", np, 0);

        access(1'b1, 5'h00, 32'h41, 4'h1, lat, d, np, nr, pat);
        chk("tx_best_lat", lat, 2);
        chk("tx_best_push", np, 1);

        uart_wr_ready = 1'b0;
        wait_idle();
        mmio_req = 1'b1;
        mmio_we = 1'b1;
        mmio_addr = 5'h00;
        mmio_wdata = 32'h41;
        mmio_be = 4'h1;
        tick();
        mmio_req = 1'b0;
        mmio_we = 1'b0;
        bad = 0;
        cnt = 0;
        for (int i = 0; i < 5; i++) begin
            if (!(uart_wr_req && uart_wr_data == 8'h41 && !mmio_ready && !mmio_rvalid)) bad++;
            if (uart_wr_req && uart_wr_ready) cnt++;
            tick();
        end
        chk("tx_hold_bad_cycles", bad, 0);
        uart_wr_ready = 1'b1;
        chk("tx_hold_req_at_p", {31'h0, uart_wr_req}, 32'h1);
        if (uart_wr_req && uart_wr_ready) cnt++;
        tick();
        if (uart_wr_req && uart_wr_ready) cnt++;
        chk("tx_hold_rvalid_p1", {31'h0, mmio_rvalid}, 32'h1);
        chk("tx_hold_pushes", cnt, 1);
        tick();
        chk("thru_ready", {31'h0, mmio_ready}, 32'h1);

        uart_rd_data = 8'h5A;
        rx_loaded = pops_total + 1;
        access(1'b0, 5'h04, 32'h0, 4'hF, lat, d, np, nr, pat);
        chk("rx_lat", lat, 3);
        chk("rx_data", d, 32'h15A);
        chk("rx_pops", nr, 1);
        chk("rx_pop_at", pat, 1);
        access(1'b0, 5'h04, 32'h0, 4'hF, lat, d, np, nr, pat);
        chk("rx_empty_data", d, 32'h0);
        chk("rx_empty_pops", nr, 0);
        chk("rx_empty_lat", lat, 3);

        during_sw_upgrade = 1'b1;
        rx_loaded = pops_total + 1;
        access(1'b1, 5'h00, 32'h77, 4'hF, lat, d, np, nr, pat);
        chk("upg_tx_lat", lat, 2);
        chk("upg_tx_push", np, 0);
        access(1'b0, 5'h04, 32'h0, 4'hF, lat, d, np, nr, pat);
        chk("upg_rx_data", d, 32'h0);
        chk("upg_rx_pops", nr, 0);
        access(1'b0, 5'h08, 32'h0, 4'hF, lat, d, np, nr, pat);
        chk("upg_status", d, 32'h4);
        during_sw_upgrade = 1'b0;
        rx_loaded = pops_total;

        uart_wr_ready = 1'b0;
        wait_idle();
        mmio_req = 1'b1;
        mmio_we = 1'b1;
        mmio_addr = 5'h00;
        mmio_wdata = 32'h33;
        mmio_be = 4'h1;
        tick();
        mmio_req = 1'b0;
        mmio_we = 1'b0;
        chk("midrst_in_push", {31'h0, uart_wr_req}, 32'h1);
        rstb = 1'b0;
        tick();
        chk("midrst_wr_req", {31'h0, uart_wr_req}, 32'h0);
        chk("midrst_rvalid", {31'h0, mmio_rvalid}, 32'h0);
        rstb = 1'b1;
        uart_wr_ready = 1'b1;
        cnt = 0;
        tick();
        chk("midrst_idle_ready", {31'h0, mmio_ready}, 32'h1);
        for (int i = 0; i < 3; i++) begin
            if (mmio_rvalid || uart_wr_req) cnt++;
            tick();
        end
        chk("midrst_no_resp", cnt, 0);

`ifdef UART_IRQ_EN
        access(1'b1, 5'h10, 32'h1, 4'hF, lat, d, np, nr, pat);
        access(1'b0, 5'h10, 32'h0, 4'hF, lat, d, np, nr, pat);
        chk("irqen_rd", d, 32'h1);
        tick();
        chk("irq_idle", {31'h0, irq}, 32'h0);
        rx_loaded = pops_total + 1;
        chk("irq_same_cycle", {31'h0, irq}, 32'h0);
        tick();
        chk("irq_rise", {31'h0, irq}, 32'h1);
        access(1'b0, 5'h08, 32'h0, 4'hF, lat, d, np, nr, pat);
        chk("irq_status", d, 32'h8);
        access(1'b0, 5'h04, 32'h0, 4'hF, lat, d, np, nr, pat);
        chk("irq_drain_data", d, 32'h15A);
        tick();
        chk("irq_fall", {31'h0, irq}, 32'h0);
`else
        access(1'b1, 5'h10, 32'h3, 4'hF, lat, d, np, nr, pat);
        chk("irqen_wr_lat", lat, 2);
        access(1'b0, 5'h10, 32'h0, 4'hF, lat, d, np, nr, pat);
        chk("irqen_rd_zero", d, 32'h0);
        rx_loaded = pops_total + 1;
        tick();
        tick();
        chk("irq_tied_low", {31'h0, irq}, 32'h0);
        access(1'b0, 5'h08, 32'h0, 4'hF, lat, d, np, nr, pat);
        chk("status_no_irq", d, 32'h0);
        rx_loaded = pops_total;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
